// File: rtl/data_mem_responder_if.sv
// Data-memory command/response bus between an initiator and data_mem_responder.
//
// Handshake:
//   A command transfers on a rising clk edge where mem_d_cmd is READ or WRITE
//   and mem_d_cmd_ready is 1. At that edge the responder captures mem_d_addr,
//   mem_wdata and mem_wmask, so later changes to them have no effect.
//   mem_d_cmd_ready stays low until the command has completed.
//   mem_rdata_valid is a one-cycle strobe and is never back-pressured.
//   mem_rdata keeps its value until the next read completes.
//
// Signals:
//   mem_d_cmd        initiator -> responder  3'd0 NOP, 3'd1 READ, 3'd2 WRITE; other codes act as NOP
//   mem_d_cmd_ready  responder -> initiator  a command can be accepted this cycle
//   mem_d_addr       initiator -> responder  byte address
//   mem_wdata        initiator -> responder  write data, right-aligned
//   mem_wmask        initiator -> responder  bit-granular write mask, right-aligned
//   mem_rdata        responder -> initiator  read data, right-aligned to the addressed byte
//   mem_rdata_valid  responder -> initiator  mem_rdata holds a completed read
interface data_mem_responder_if;
    logic [2:0]  mem_d_cmd;
    logic        mem_d_cmd_ready;
    logic [31:0] mem_d_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    modport master (
        output mem_d_cmd,
        output mem_d_addr,
        output mem_wdata,
        output mem_wmask,
        input  mem_d_cmd_ready,
        input  mem_rdata,
        input  mem_rdata_valid
    );

    modport slave (
        input  mem_d_cmd,
        input  mem_d_addr,
        input  mem_wdata,
        input  mem_wmask,
        output mem_d_cmd_ready,
        output mem_rdata,
        output mem_rdata_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder. It serves one command at a time from an
// internal array of DEPTH_WORDS 32-bit words. A command completes LATENCY
// cycles after it is accepted. Reads spend one more cycle in RESP, where they
// drive the valid strobe.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset (array contents are kept)
//   bus        data_mem_responder_if.slave (handshake described in the interface file)
//   dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module data_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_mem_responder_if.slave   bus,
    output logic [1:0]            dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] rdata_q;

    // Captured command; only the address bits that select a word and byte are kept.
    logic          is_write_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   wmask_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          complete;
    logic [AW-1:0] idx_q;
    logic [4:0]    sh_q;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;

    assign accept   = (state == IDLE) &&
                      ((bus.mem_d_cmd == CMD_READ) || (bus.mem_d_cmd == CMD_WRITE));
    assign complete = (state == BUSY) && (cnt == 4'd0);

    // Upper address bits alias; sh is the byte offset in bits.
    assign idx_q   = addr_q[AW+1:2];
    assign sh_q    = {addr_q[1:0], 3'b000};
    // Mask and data bits shifted beyond bit 31 are discarded by the 32-bit width.
    assign wr_mask = wmask_q << sh_q;
    assign wr_data = wdata_q << sh_q;
    assign rd_word = mem[idx_q] >> sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            rdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wmask_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_write_q <= (bus.mem_d_cmd == CMD_WRITE);
                        addr_q     <= bus.mem_d_addr[AW+1:0];
                        wdata_q    <= bus.mem_wdata;
                        wmask_q    <= bus.mem_wmask;
                        cnt        <= CNT_INIT;
                        ready_q    <= 1'b0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (is_write_q) begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            rdata_q <= rd_word;
                            valid_q <= 1'b1;
                            state   <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // While rst_n is low the state is IDLE, so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (complete && is_write_q) begin
            mem[idx_q] <= (mem[idx_q] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    assign bus.mem_d_cmd_ready = ready_q;
    assign bus.mem_rdata_valid = valid_q;
    assign bus.mem_rdata       = rdata_q;
    assign dbg_state           = state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam int DEPTH = 4096;
    localparam int LAT   = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // The array is a sparse map of word index to value. Timing is tracked as
    // absolute edge numbers derived from the latency rules.
    logic [31:0] mdl [int];
    int          edge_n    = 0;
    int          free_edge = 0;
    int          done_edge = 0;
    bit          pend      = 0;
    bit          pend_read = 0;
    logic [31:0] p_addr, p_wdata, p_wmask;
    bit          m_ready   = 1;
    bit          m_valid   = 0;
    logic [31:0] m_rdata   = 32'd0;
    int          e;
    bit          acc;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mdl_get(input int k);
        if (mdl.exists(k)) return mdl[k];
        return 32'd0;
    endfunction

    // Bit i of the word takes data bit (i - 8*off) where that mask bit is set.
    function automatic logic [31:0] apply_w(input logic [31:0] w, input logic [31:0] d,
                                            input logic [31:0] m, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 32; i++) begin
            int j;
            j = i - 8 * int'(off);
            if (j >= 0 && m[j]) r[i] = d[j];
        end
        return r;
    endfunction

    function automatic logic [31:0] rd_shift(input logic [31:0] w, input logic [1:0] off);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            int j;
            j = i + 8 * int'(off);
            if (j < 32) r[i] = w[j];
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      = 0;
            free_edge = edge_n;
            m_ready   = 1;
            m_valid   = 0;
            m_rdata   = 32'd0;
        end else begin
            e       = edge_n;
            m_valid = 0;
            acc     = (e >= free_edge) && (bus.mem_d_cmd == 3'd1 || bus.mem_d_cmd == 3'd2);
            if (pend && e == done_edge) begin
                pend = 0;
                if (pend_read) begin
                    m_rdata = rd_shift(mdl_get(widx(p_addr)), p_addr[1:0]);
                    m_valid = 1;
                end else begin
                    mdl[widx(p_addr)] = apply_w(mdl_get(widx(p_addr)), p_wdata, p_wmask, p_addr[1:0]);
                end
            end
            if (acc) begin
                pend      = 1;
                pend_read = (bus.mem_d_cmd == 3'd1);
                p_addr    = bus.mem_d_addr;
                p_wdata   = bus.mem_wdata;
                p_wmask   = bus.mem_wmask;
                done_edge = e + LAT;
                free_edge = e + LAT + (pend_read ? 2 : 1);
            end
            edge_n  = e + 1;
            m_ready = (edge_n >= free_edge);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc_ready", {31'd0, bus.mem_d_cmd_ready}, {31'd0, m_ready});
        chk("cyc_valid", {31'd0, bus.mem_rdata_valid}, {31'd0, m_valid});
        chk("cyc_rdata", bus.mem_rdata, m_rdata);
    end

    // ---------------- drivers ----------------
    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.mem_d_cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        wait_ready();
        bus.mem_d_cmd  = c;
        bus.mem_d_addr = a;
        bus.mem_wdata  = d;
        bus.mem_wmask  = m;
        @(posedge clk);
        @(negedge clk);
        bus.mem_d_cmd = 3'd0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        issue(3'd2, a, d, m);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data);
        bit got;
        got  = 0;
        data = 'x;
        issue(3'd1, a, 32'd0, 32'd0);
        for (int i = 0; i < 64; i++) begin
            if (bus.mem_rdata_valid) begin
                data = bus.mem_rdata;
                got  = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          nstrobe;
        int          first_i;
        int          last_i;

        bus.mem_d_cmd  = 3'd0;
        bus.mem_d_addr = 32'd0;
        bus.mem_wdata  = 32'd0;
        bus.mem_wmask  = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, bus.mem_d_cmd_ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.mem_rdata_valid}, 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Full-word write then read back.
        do_write(32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
        do_read(32'h10, d);
        chk("rd_0x10", d, 32'hDEADBEEF);

        // Byte-lane write and shifted reads.
        do_write(32'h20, 32'h11223344, 32'hFFFFFFFF);
        do_write(32'h22, 32'h000000AA, 32'h000000FF);
        do_read(32'h20, d);
        chk("rd_lane_word", d, 32'h11AA3344);
        do_read(32'h23, d);
        chk("rd_0x23", d, 32'h00000011);
        do_write(32'h20, 32'h00000000, 32'h00000000);
        do_read(32'h20, d);
        chk("rd_mask0", d, 32'h11AA3344);
        do_write(32'h23, 32'h0000FFFF, 32'h0000FFFF);
        do_read(32'h21, d);
        chk("rd_overflow_lane", d, 32'h00FFAA33);

        // Read timing with commands toggled while busy.
        wait_ready();
        bus.mem_d_cmd  = 3'd1;
        bus.mem_d_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        bus.mem_d_cmd  = 3'd2;
        bus.mem_d_addr = 32'h40;
        bus.mem_wdata  = 32'h1;
        bus.mem_wmask  = 32'hFFFFFFFF;
        for (int k = 0; k <= LAT + 1; k++) begin
            chk($sformatf("tim_ready_k%0d", k), {31'd0, bus.mem_d_cmd_ready}, (k == LAT + 1) ? 32'd1 : 32'd0);
            chk($sformatf("tim_valid_k%0d", k), {31'd0, bus.mem_rdata_valid}, (k == LAT) ? 32'd1 : 32'd0);
            if (k == LAT) chk("tim_rdata", bus.mem_rdata, 32'hDEADBEEF);
            if (k == 0) bus.mem_d_cmd = 3'd1;
            if (k == 1) bus.mem_d_cmd = 3'd0;
            @(negedge clk);
        end

        // Undefined command code is a NOP.
        bus.mem_d_cmd = 3'd5;
        @(posedge clk);
        @(negedge clk);
        chk("cmd5_ready", {31'd0, bus.mem_d_cmd_ready}, 32'd1);
        chk("cmd5_state", {30'd0, dbg_state}, 32'd0);
        bus.mem_d_cmd = 3'd0;

        // Address aliasing.
        do_write(32'h00004004, 32'hCAFEF00D, 32'hFFFFFFFF);
        do_read(32'h00000004, d);
        chk("rd_alias", d, 32'hCAFEF00D);

        // Reset during BUSY of a write.
        do_write(32'h30, 32'h0, 32'hFFFFFFFF);
        wait_ready();
        bus.mem_d_cmd  = 3'd2;
        bus.mem_d_addr = 32'h30;
        bus.mem_wdata  = 32'h55555555;
        bus.mem_wmask  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.mem_d_cmd = 3'd0;
        chk("abort_busy", {30'd0, dbg_state}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, bus.mem_d_cmd_ready}, 32'd1);
        chk("abort_valid", {31'd0, bus.mem_rdata_valid}, 32'd0);
        chk("abort_rdata", bus.mem_rdata, 32'd0);
        chk("abort_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        bus.mem_d_cmd  = 3'd1;
        bus.mem_d_addr = 32'h10;
        repeat (2) @(negedge clk);
        chk("inrst_state", {30'd0, dbg_state}, 32'd0);
        chk("inrst_ready", {31'd0, bus.mem_d_cmd_ready}, 32'd1);
        bus.mem_d_cmd = 3'd0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        do_read(32'h30, d);
        chk("rd_after_abort", d, 32'h00000000);

        // Back-to-back reads with the command held.
        wait_ready();
        bus.mem_d_cmd  = 3'd1;
        bus.mem_d_addr = 32'h10;
        nstrobe = 0;
        first_i = -1;
        last_i  = 0;
        for (int i = 0; i < 4 * (LAT + 2); i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_rdata_valid) begin
                if (nstrobe == 0) first_i = i;
                else chk("b2b_gap", 32'(i - last_i), 32'(LAT + 2));
                last_i = i;
                nstrobe++;
            end
        end
        bus.mem_d_cmd = 3'd0;
        chk("b2b_count", 32'(nstrobe), 32'd4);
        chk("b2b_first", 32'(first_i), 32'(LAT));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the internal array; power of two.
REQ-002 Parameter LATENCY, default 2: cycles from command acceptance to completion; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_d_cmd  input  3  command: 3'd0 NOP, 3'd1 READ, 3'd2 WRITE; other codes treated as NOP.
REQ-006 mem_d_cmd_ready  output  1  responder can accept a command this cycle.
REQ-007 mem_d_addr  input  32  byte address.
REQ-008 mem_wdata  input  32  write data, right-aligned (lane 0 = bits 7:0).
REQ-009 mem_wmask  input  32  bit-granular write mask, right-aligned.
REQ-010 mem_rdata  output  32  read data, right-aligned to the addressed byte.
REQ-011 mem_rdata_valid  output  1  one-cycle strobe: mem_rdata holds a completed read.

Function
REQ-012 States: IDLE, BUSY, RESP; only IDLE asserts mem_d_cmd_ready.
REQ-013 Acceptance: rising edge with mem_d_cmd_ready=1 and mem_d_cmd in {READ, WRITE}; addr, wdata, wmask, cmd captured at that edge; later input changes have no effect.
REQ-014 IDLE -> BUSY on acceptance; latency counter loaded with LATENCY-1; mem_d_cmd_ready deasserted at the same edge.
REQ-015 BUSY: counter decrements each edge; at counter=0 the edge completes the command.
REQ-016 Read completion: that edge loads mem_rdata and sets mem_rdata_valid=1, state -> RESP; the next edge clears mem_rdata_valid and returns to IDLE (ready=1).
REQ-017 Write completion: that edge updates the array and returns directly to IDLE (ready=1); mem_rdata_valid is not asserted for writes; mem_rdata is unchanged.
REQ-018 Read timing: accepted at edge T -> mem_rdata_valid high for exactly the cycle after edge T+LATENCY; next acceptance no earlier than edge T+LATENCY+2.
REQ-019 Write timing: accepted at edge T -> ready high after edge T+LATENCY; next acceptance no earlier than edge T+LATENCY+1.
REQ-020 Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around); sh = 8*addr[1:0].
REQ-021 Write: m = (wmask << sh) truncated to 32 bits, d = (wdata << sh) truncated; word <= (word & ~m) | (d & m); bits shifted past bit 31 discarded.
REQ-022 Read: mem_rdata = word >> sh, zero-filled; sign/zero extension is the initiator's responsibility.
REQ-023 Read sees the array state after all previously completed writes (commands serialized, no reordering).
REQ-024 Command held asserted after acceptance is re-accepted at the next edge where ready=1; initiator must return to NOP to avoid repeats.
REQ-025 wmask=0 write completes with normal timing and leaves the array unchanged.

Reset
REQ-026 rst_n low forces immediately: state IDLE, counter 0, mem_d_cmd_ready=1, mem_rdata=0, mem_rdata_valid=0.
REQ-027 Reset during BUSY or RESP aborts the command: no array write, no mem_rdata_valid strobe.
REQ-028 Array contents are not cleared by reset.
REQ-029 No command is accepted at any edge while rst_n is low; first acceptance possible at the first edge after deassertion.

Verification
REQ-030 WRITE addr 0x10 wdata 0xDEADBEEF mask 0xFFFFFFFF, then READ 0x10, LATENCY=2 -> rdata_valid one cycle after edge T+2 of the read, rdata=0xDEADBEEF.
REQ-031 Word 0x20 = 0x11223344; WRITE addr 0x22 wdata 0x000000AA mask 0x000000FF -> word 0x11AA3344; READ 0x23 -> rdata 0x00000011.
REQ-032 Timing: read accepted at edge T, LATENCY=3 -> ready low from T through T+3, valid only in cycle after T+3, ready high after T+4; cmd toggled during BUSY ignored.
REQ-033 Reset asserted mid-BUSY of WRITE 0x30 = 0x55555555 (prior 0x0) -> outputs at reset values immediately, later READ 0x30 returns 0x00000000.
REQ-034 Aliasing: DEPTH_WORDS=4096, WRITE 0x00004004 = 0xCAFEF00D -> READ 0x00000004 returns 0xCAFEF00D; invalid cmd 3'd5 while IDLE -> no acceptance, ready stays 1.
REQ-035 Back-to-back: cmd held at READ continuously -> one acceptance every LATENCY+2 cycles, one valid strobe per acceptance.
